vga_timing_gen: RTL

//  Runtime-programmable VGA raster timing generator. Consumes a vga_params_t (H and V line_t) and produces
//  hs/vs, data-enable, the pixel X/Y coordinate and frame/line markers. Sits between the mode-select logic
//  (get_vga_params) and the pixel source / output encoder, in the pixel clock domain.

---
 rtl/vga_timing_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: runtime-programmable VGA raster timing generator (hs/vs, de, x/y, sof/eol)
// with a frame-boundary shadow of the timing parameters.
package vga_pkg;
   localparam int LineCounterWidth = 11;
   localparam int PosCounterWidthX = 11;
   localparam int PosCounterWidthY = 11;

   typedef struct packed {
      logic [LineCounterWidth-1:0] visible_area;
      logic [LineCounterWidth-1:0] front_porch;
      logic [LineCounterWidth-1:0] sync_pulse;
      logic [LineCounterWidth-1:0] back_porch;
      logic                        polarity;
   } line_t;

   typedef struct packed {
      line_t h;
      line_t v;
   } vga_params_t;

   typedef struct packed {
      logic hs;
      logic vs;
   } vga_sync_t;

   typedef enum logic [1:0] {SEG_VIS, SEG_FP, SEG_SYNC, SEG_BP} seg_e;

   function automatic logic [LineCounterWidth-1:0] seg_len(input seg_e s, input line_t l);
      return (s == SEG_VIS)  ? l.visible_area :
             (s == SEG_FP)   ? l.front_porch  :
             (s == SEG_SYNC) ? l.sync_pulse   : l.back_porch;
   endfunction

   // First non-empty segment after s; visible is never empty while the raster runs.
   function automatic seg_e next_seg(input seg_e s, input line_t l);
      return (s == SEG_VIS && l.front_porch != '0)                 ? SEG_FP   :
             (s != SEG_SYNC && s != SEG_BP && l.sync_pulse != '0)  ? SEG_SYNC :
             (s != SEG_BP && l.back_porch != '0)                   ? SEG_BP   : SEG_VIS;
   endfunction
endpackage

module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int LINE_W = LineCounterWidth,
   parameter int X_W    = PosCounterWidthX,
   parameter int Y_W    = PosCounterWidthY
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  vga_params_t params_i,
   output vga_sync_t   sync_o,
   output logic        de_o,
   output logic [X_W-1:0] x_o,
   output logic [Y_W-1:0] y_o,
   output logic        sof_o,
   output logic        eol_o
);
   vga_params_t     sh_q, sh_d;
   logic            run_q, run_d;
   seg_e            h_st_q, h_st_d, v_st_q, v_st_d, h_nx, v_nx;
   logic [LINE_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, h_len, v_len;
   logic            h_wrap, v_wrap, frame_end, load;
   vga_sync_t       sync_q, sync_d;
   logic            de_q, de_d, de_n, sof_q, sof_d, eol_q, eol_d;
   logic [X_W-1:0]  x_q, x_d;
   logic [Y_W-1:0]  y_q, y_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q    <= '0;
         run_q   <= 1'b0;
         h_st_q  <= SEG_VIS;
         v_st_q  <= SEG_VIS;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         sync_q  <= '0;
         de_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         run_q   <= run_d;
         h_st_q  <= h_st_d;
         v_st_q  <= v_st_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         sync_q  <= sync_d;
         de_q    <= de_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
      end
   end

   // Next raster position; the shadow reloads when idle or on the final clock of a frame.
   always_comb begin
      h_len     = LINE_W'(seg_len(h_st_q, sh_q.h));
      v_len     = LINE_W'(seg_len(v_st_q, sh_q.v));
      h_nx      = next_seg(h_st_q, sh_q.h);
      v_nx      = next_seg(v_st_q, sh_q.v);
      h_wrap    = h_cnt_q == h_len - LINE_W'(1);
      v_wrap    = v_cnt_q == v_len - LINE_W'(1);
      frame_end = h_wrap && h_nx == SEG_VIS && v_wrap && v_nx == SEG_VIS;
      load      = en_i && (!run_q || frame_end);
      sh_d      = load ? params_i : sh_q;
      run_d     = load ? (params_i.h.visible_area != '0 && params_i.v.visible_area != '0) : run_q;
      h_st_d    = h_st_q;
      v_st_d    = v_st_q;
      h_cnt_d   = h_cnt_q;
      v_cnt_d   = v_cnt_q;
      if (load) begin
         h_st_d  = SEG_VIS;
         v_st_d  = SEG_VIS;
         h_cnt_d = '0;
         v_cnt_d = '0;
      end else if (en_i) begin
         h_st_d  = h_wrap ? h_nx : h_st_q;
         h_cnt_d = h_wrap ? '0 : h_cnt_q + LINE_W'(1);
         if (h_wrap && h_nx == SEG_VIS) begin
            v_st_d  = v_wrap ? v_nx : v_st_q;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + LINE_W'(1);
         end
      end
   end

   always_comb begin
      de_n      = run_d && h_st_d == SEG_VIS && v_st_d == SEG_VIS;
      sync_d.hs = en_i ? ((run_d && h_st_d == SEG_SYNC) ? sh_d.h.polarity : ~sh_d.h.polarity) : sync_q.hs;
      sync_d.vs = en_i ? ((run_d && v_st_d == SEG_SYNC) ? sh_d.v.polarity : ~sh_d.v.polarity) : sync_q.vs;
      de_d      = en_i ? de_n : de_q;
      x_d       = en_i ? (de_n ? X_W'(h_cnt_d) : '0) : x_q;
      y_d       = en_i ? ((run_d && v_st_d == SEG_VIS) ? Y_W'(v_cnt_d) : '0) : y_q;
      sof_d     = en_i && de_n && h_cnt_d == '0 && v_cnt_d == '0;
      eol_d     = en_i && de_n && h_cnt_d == LINE_W'(sh_d.h.visible_area) - LINE_W'(1);
   end

   assign sync_o = sync_q;
   assign de_o   = de_q;
   assign x_o    = x_q;
   assign y_o    = y_q;
   assign sof_o  = sof_q;
   assign eol_o  = eol_q;
endmodule
